ram_march_bist: RTL and testbench

Built-in self-test engine that drives one port of the team's true dual-port `ram` with a March C- sequence and checks the read data. It sits directly upstream of the RAM port: it owns address, write-enable and write data, and consumes the port's registered (1-cycle) read data. It reports pass/fail plus the first failing address, element and observed word.

---
 rtl/ram_march_bist_if.sv | 24 ++
 rtl/ram_march_bist.sv | 161 ++++++++++++++++
 tb/tb_ram_march_bist.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_march_bist_if.sv
// rtl/ram_march_bist_if.sv - RAM port bundle between the March BIST engine and one RAM port
interface ram_march_bist_if #(
    parameter int ADDR_WIDTH = -1,
    parameter int DATA_WIDTH = -1
);
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  we_o;
    logic [DATA_WIDTH-1:0] data_wr_o;
    logic [DATA_WIDTH-1:0] data_rd_i;

    modport master (
        output addr_o,
        output we_o,
        output data_wr_o,
        input  data_rd_i
    );

    modport slave (
        input  addr_o,
        input  we_o,
        input  data_wr_o,
        output data_rd_i
    );
endinterface

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- self-test engine driving one registered-read RAM port
module ram_march_bist #(
    parameter int ADDR_WIDTH = -1,
    parameter int DATA_WIDTH = -1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [2:0]            err_elem_o,
    output logic [DATA_WIDTH-1:0] err_data_o,
    ram_march_bist_if.master      ram
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]            elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_phase_q;

    logic                  vld_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [2:0]            rd_elem_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [2:0]            err_elem_q;
    logic [DATA_WIDTH-1:0] err_data_q;

    logic                  rw_elem;
    logic                  is_read;
    logic                  down;
    logic                  addr_end;
    logic                  last_op;
    logic                  step;
    logic                  mismatch;
    logic                  start_run;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    // E1..E4 are read-then-write per address; E0 writes only, E5 reads only
    assign rw_elem  = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign is_read  = (elem_q == 3'd5) || (rw_elem && !wr_phase_q);
    assign down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign addr_end = down ? (addr_q == '0) : (addr_q == '1);
    assign last_op  = (elem_q == 3'd5) && (addr_q == '1);
    assign step     = !rw_elem || wr_phase_q;
    assign wr_word  = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
    assign rd_word  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    assign mismatch = vld_q && (ram.data_rd_i != exp_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        start_run     = 1'b0;
        busy_o        = 1'b0;
        ram.addr_o    = '0;
        ram.we_o      = 1'b0;
        ram.data_wr_o = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                busy_o        = 1'b1;
                ram.addr_o    = addr_q;
                ram.we_o      = !is_read;
                ram.data_wr_o = is_read ? '0 : wr_word;
                if (mismatch) begin
                    state_d = ST_DONE;
                end else if (last_op) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address/element sequencer; freezes as soon as a mismatch is seen
    always_ff @(posedge clk_i) begin
        if (rst_i || start_run) begin
            elem_q     <= 3'd0;
            addr_q     <= '0;
            wr_phase_q <= 1'b0;
        end else if (state_q == ST_RUN && !mismatch) begin
            if (!step) begin
                wr_phase_q <= 1'b1;
            end else begin
                wr_phase_q <= 1'b0;
                if (addr_end) begin
                    elem_q <= elem_q + 3'd1;
                    addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
                end else begin
                    addr_q <= down ? addr_q - 1'b1 : addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= 1'b0;
            exp_q     <= '0;
            rd_elem_q <= 3'd0;
            rd_addr_q <= '0;
        end else begin
            vld_q     <= (state_q == ST_RUN) && is_read && !mismatch;
            exp_q     <= rd_word;
            rd_elem_q <= elem_q;
            rd_addr_q <= addr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_run) begin
            fail_q     <= 1'b0;
            err_addr_q <= '0;
            err_elem_q <= 3'd0;
            err_data_q <= '0;
        end else if (mismatch && !fail_q) begin
            fail_q     <= 1'b1;
            err_addr_q <= rd_addr_q;
            err_elem_q <= rd_elem_q;
            err_data_q <= ram.data_rd_i;
        end
    end

    assign done_o     = (state_q == ST_DONE);
    assign pass_o     = done_o && !fail_q;
    assign fail_o     = done_o && fail_q;
    assign err_addr_o = err_addr_q;
    assign err_elem_o = err_elem_q;
    assign err_data_o = err_data_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// tb/tb_ram_march_bist.sv - randomized March C- BIST bench with faulty-RAM model and op-list reference
module tb_ram_march_bist;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;

    typedef struct {
        int            a;
        bit            we;
        logic [DW-1:0] v;
        int            elem;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, fail;
    logic [AW-1:0] err_addr;
    logic [2:0]    err_elem;
    logic [DW-1:0] err_data;

    ram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

    ram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .fail_o     (fail),
        .err_addr_o (err_addr),
        .err_elem_o (err_elem),
        .err_data_o (err_data),
        .ram        (ram_if)
    );

    always #5 clk = ~clk;

    bit sa_en = 1'b0, sa_val = 1'b0, cf_en = 1'b0, scramble = 1'b0;
    int sa_addr = 0, sa_bit = 0, cf_agg = 0, cf_vic = 0, cf_bit = 0;
    int n_checks = 0, n_fail = 0;
    op_t ops[$];

    logic [DW-1:0] mem [N];

    function automatic logic [DW-1:0] fault_read(input logic [DW-1:0] w, input int a);
        logic [DW-1:0] r = w;
        if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
        return r;
    endfunction

    // Faulty RAM port: stuck-at on read, inversion coupling on aggressor write
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
        end else if (ram_if.we_o) begin
            mem[ram_if.addr_o] <= ram_if.data_wr_o;
            if (cf_en && int'(ram_if.addr_o) == cf_agg)
                mem[cf_vic][cf_bit] <= ~mem[cf_vic][cf_bit];
        end
        ram_if.data_rd_i <= fault_read(mem[ram_if.addr_o], int'(ram_if.addr_o));
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expand March C- into a flat op list, then replay it on an ideal faulty memory
    task automatic build_ref(output int fidx, output logic [DW-1:0] fdata);
        logic [DW-1:0] rmem [N];
        logic [DW-1:0] ones = '1;
        logic [DW-1:0] zero = '0;
        logic [DW-1:0] obs;
        int a;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                if (e != 0) ops.push_back('{a: a, we: 1'b0, v: ((e == 2 || e == 4) ? ones : zero), elem: e});
                if (e != 5) ops.push_back('{a: a, we: 1'b1, v: ((e == 1 || e == 3) ? ones : zero), elem: e});
            end
        end
        for (int i = 0; i < N; i++) rmem[i] = zero;
        fidx  = -1;
        fdata = zero;
        foreach (ops[i]) begin
            if (!ops[i].we) begin
                obs = fault_read(rmem[ops[i].a], ops[i].a);
                if (obs != ops[i].v) begin
                    fidx  = i;
                    fdata = obs;
                    break;
                end
            end else begin
                rmem[ops[i].a] = ops[i].v;
                if (cf_en && ops[i].a == cf_agg) rmem[cf_vic][cf_bit] = ~rmem[cf_vic][cf_bit];
            end
        end
    endtask

    task automatic run_one(input string tag, input bit hold);
        int fidx, nops, dcyc, terr, serr;
        logic [DW-1:0] fdata, ed;
        logic [AW-1:0] ea;
        logic          ewe;
        build_ref(fidx, fdata);
        if (fidx < 0) begin
            nops = NOPS;
            dcyc = NOPS + 2;
        end else begin
            nops = (fidx + 2 < NOPS) ? fidx + 2 : NOPS;
            dcyc = fidx + 3;
        end
        @(negedge clk) scramble = 1'b1;
        @(negedge clk) scramble = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        terr = 0;
        serr = 0;
        for (int t = 1; t <= dcyc; t++) begin
            @(negedge clk);
            if (t <= nops) begin
                ea  = AW'(ops[t-1].a);
                ewe = ops[t-1].we;
                ed  = ewe ? ops[t-1].v : '0;
            end else begin
                ea  = '0;
                ewe = 1'b0;
                ed  = '0;
            end
            if (ram_if.addr_o !== ea || ram_if.we_o !== ewe || ram_if.data_wr_o !== ed) terr++;
            if (busy !== (t < dcyc) || done !== (t == dcyc)) serr++;
            if (t < dcyc && (pass !== 1'b0 || fail !== 1'b0)) serr++;
        end
        chk({tag, "_trace"}, 32'(terr), 32'd0);
        chk({tag, "_status"}, 32'(serr), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'(fidx < 0));
        chk({tag, "_fail"}, 32'(fail), 32'(fidx >= 0));
        chk({tag, "_err_addr"}, 32'(err_addr), (fidx < 0) ? 32'd0 : 32'(ops[fidx].a));
        chk({tag, "_err_elem"}, 32'(err_elem), (fidx < 0) ? 32'd0 : 32'(ops[fidx].elem));
        chk({tag, "_err_data"}, 32'(err_data), 32'(fdata));
        if (hold) begin
            @(negedge clk);
            chk({tag, "_restart"}, 32'({done, busy, ram_if.we_o, ram_if.addr_o}), 32'({1'b0, 1'b1, 1'b1, {AW{1'b0}}}));
            start = 1'b0;
            for (int c = 0; c < NOPS + 5 && !done; c++) @(negedge clk);
            chk({tag, "_second_done"}, 32'({done, pass}), 32'({1'b1, fidx < 0}));
        end else begin
            @(negedge clk);
            chk({tag, "_held"}, 32'({done, pass, fail}), 32'({1'b1, fidx < 0, fidx >= 0}));
        end
    endtask

    task automatic clear_faults();
        sa_en = 1'b0;
        cf_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, pass, fail, err_addr, err_elem, err_data,
                              ram_if.addr_o, ram_if.we_o, ram_if.data_wr_o}, 32'd0);
        rst = 1'b0;

        clear_faults();
        run_one("clean", 1'b0);

        sa_en = 1'b1; sa_addr = 5; sa_bit = 0; sa_val = 1'b1;
        run_one("stuck", 1'b0);
        chk("stuck_plan", 32'({fail, err_elem, err_addr, err_data}), 32'({1'b1, 3'd1, 4'd5, 8'h01}));
        clear_faults();

        cf_en = 1'b1; cf_agg = 3; cf_vic = 7; cf_bit = 2;
        run_one("couple", 1'b0);
        chk("couple_plan", 32'({fail, err_elem, err_addr, err_data}), 32'({1'b1, 3'd1, 4'd7, 8'h04}));
        clear_faults();

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                sa_en   = 1'b1;
                sa_addr = $urandom_range(0, N - 1);
                sa_bit  = $urandom_range(0, DW - 1);
                sa_val  = 1'($urandom_range(0, 1));
            end else begin
                cf_en  = 1'b1;
                cf_agg = $urandom_range(0, N - 1);
                do cf_vic = $urandom_range(0, N - 1); while (cf_vic == cf_agg);
                cf_bit = $urandom_range(0, DW - 1);
            end
            run_one($sformatf("rand%0d", i), 1'b0);
            clear_faults();
        end

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset", {busy, done, pass, fail, err_addr, err_elem, err_data,
                             ram_if.addr_o, ram_if.we_o, ram_if.data_wr_o}, 32'd0);
        rst = 1'b0;
        run_one("after_reset", 1'b0);

        run_one("hold", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
